fadd_ctrl: RTL and testbench
============================

FADD_CTRL -- requirements
Module: fadd_ctrl

Interface
REQ-001 SHALL have ports clk, in, 1, system clock; one clock domain, all state updated on its rising edge.
REQ-002 SHALL have ports reset, in, 1, synchronous active-high reset.
REQ-003 SHALL have ports start, in, 1, command request pulse from the instruction sequencer.
REQ-004 SHALL have ports op, in, 2, command: 0 FADD, 1 FSUB, 2 FCMP, 3 reserved.
REQ-005 SHALL have ports ra, in, 31, rA operand (sign, 6-bit exponent, 24-bit fraction).
REQ-006 SHALL have ports v, in, 31, memory operand V, same format.
REQ-007 SHALL have ports busy, out, 1, high from accepted start until stop.
REQ-008 SHALL have ports stop, out, 1, one-cycle completion pulse.
REQ-009 SHALL have ports result, out, 31, new rA value.
REQ-010 SHALL have ports overflow, out, 1, overflow toggle request.
REQ-011 SHALL have ports cmp, out, 2, comparison indicator: 00 equal, 01 less, 10 greater.
REQ-012 SHALL have ports err, out, 1, adder timeout.
REQ-013 SHALL have ports fa_start, out, 1; fa_in1, out, 31; fa_in2, out, 31; these drive the shared adder.
REQ-014 SHALL have ports fa_out, in, 31; fa_stop, in, 1; fa_overflow, in, 1; these are returned by the shared adder.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-016 IDLE: start is accepted; ra, v and op are latched; busy rises on the next cycle; transition to ISSUE.
REQ-017 start while busy SHALL be ignored, with no latch and no queue.
REQ-018 ISSUE: fa_start=1 for exactly one cycle; fa_in1=latched ra; fa_in2=latched v for FADD; fa_in2={~v[30],v[29:0]} for FSUB/FCMP; transition to WAIT.
REQ-019 fa_in1/fa_in2 SHALL stay stable from ISSUE until leaving WAIT.
REQ-020 WAIT: on fa_stop, capture fa_out/fa_overflow and go to DONE; fa_stop in any other state SHALL be ignored.
REQ-021 DONE: stop=1 for one cycle; busy falls with stop.
REQ-022 FADD/FSUB: result=captured fa_out; overflow=fa_overflow; cmp unchanged.
REQ-023 FCMP: result unchanged; overflow=0; cmp=00 if fa_out[23:0]==0, 01 if fa_out[30]=1, else 10.
REQ-024 Nominal latency SHALL be start at cycle 0 to stop at cycle 5 with the 3-cycle adder.
REQ-025 A 3-bit WAIT counter SHALL run; 8 WAIT cycles without fa_stop forces DONE with err=1, result/overflow/cmp unchanged.
REQ-026 err SHALL be cleared on the next accepted start.
REQ-027 op=3 SHALL go IDLE -> DONE directly, with stop on cycle 2, no fa_start, and outputs unchanged.
REQ-028 result/overflow/cmp/err SHALL be registered and hold between commands.
REQ-029 overflow SHALL be cleared on the next accepted start.

Reset
REQ-030 reset SHALL force IDLE with busy=0, stop=0, fa_start=0, result=0, overflow=0, cmp=00, err=0, timeout counter=0.
REQ-031 reset mid-command SHALL abandon the command without a stop pulse; a later fa_stop SHALL be ignored.
REQ-032 reset SHALL take priority over start in the same cycle.

Configuration
REQ-033 Macro FADD_CTRL_FCMP_EN SHALL select FCMP support.
REQ-034 Defined: FCMP behaves per REQ-023.
REQ-035 Undefined: op=2 is treated as reserved per REQ-027, the cmp output is tied to 00, and the comparison logic is absent.

Structure
REQ-036 Package fpu_pkg SHALL hold the word width (31), exponent/fraction field positions, op encodings, cmp encodings, FSM state enum and the timeout limit (8).
REQ-037 SHALL contain no sub-module; fadd is instantiated alongside fadd_ctrl at the next level up and is not embedded.

Verification
REQ-038 FADD: ra=31'h21040000 (1.0), v=31'h21040000 -> stop at cycle 5, result=31'h21080000, overflow=0.
REQ-039 FSUB: ra=31'h21040000, v=31'h21040000 -> fa_in2=31'h61040000, result=31'h00000000.
REQ-040 FCMP: ra=31'h21040000, v=31'h21080000 -> cmp=01 and result unchanged; swapping the operands gives cmp=10; equal operands give cmp=00.
REQ-041 Timeout: hold fa_stop=0 -> err=1 and stop 8 WAIT cycles after ISSUE; the next FADD start clears err.
REQ-042 Busy/reset: a second start during WAIT is ignored with a single stop; reset asserted in WAIT gives no stop, and a subsequent fa_stop pulse has no effect.
REQ-043 op=3 -> stop at cycle 2 with fa_start never asserted; also rerun the FCMP case with FADD_CTRL_FCMP_EN undefined -> cmp stays 00 and fa_start is never asserted.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point add controller: word layout,
// command and comparison encodings, controller state encoding and the
// adder response timeout.
package fpu_pkg;

   // 31-bit word: sign, 6-bit exponent, 24-bit fraction
   localparam int WORD_W   = 31;
   localparam int SIGN_BIT = 30;
   localparam int EXP_MSB  = 29;
   localparam int EXP_LSB  = 24;
   localparam int FRAC_MSB = 23;
   localparam int FRAC_LSB = 0;

   // Commands from the instruction sequencer
   typedef enum logic [1:0] {
      OP_FADD = 2'd0,
      OP_FSUB = 2'd1,
      OP_FCMP = 2'd2,
      OP_RSVD = 2'd3
   } op_e;

   // Comparison indicator
   typedef enum logic [1:0] {
      CMP_EQ = 2'b00,
      CMP_LT = 2'b01,
      CMP_GT = 2'b10
   } cmp_e;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Cycles spent in WAIT without an adder response before giving up
   localparam int TIMEOUT_LIMIT = 8;
   localparam int TMO_W         = 3;

   // Flip the sign bit; subtraction and comparison feed -V to the adder
   function automatic logic [WORD_W-1:0] negate(input logic [WORD_W-1:0] x);
      return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
   endfunction

endpackage

// File: rtl/fadd_ctrl.sv
// fadd_ctrl: sequences FADD / FSUB / FCMP commands onto a shared
// multi-cycle floating-point adder that lives beside this block.
// Operands are latched on an accepted start, the adder is started once,
// its answer is captured and a one-cycle stop pulse closes the command.
// A WAIT timeout forces completion with err set.
// Build option: define FADD_CTRL_FCMP_EN to include FCMP support; without
// it op=2 behaves like the reserved op and cmp is tied to 00.
module fadd_ctrl
   import fpu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WORD_W-1:0] ra,
   input  logic [WORD_W-1:0] v,
   output logic              busy,
   output logic              stop,
   output logic [WORD_W-1:0] result,
   output logic              overflow,
   output logic [1:0]        cmp,
   output logic              err,
   output logic              fa_start,
   output logic [WORD_W-1:0] fa_in1,
   output logic [WORD_W-1:0] fa_in2,
   input  logic [WORD_W-1:0] fa_out,
   input  logic              fa_stop,
   input  logic              fa_overflow
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [WORD_W-1:0] ra_q, ra_d;
   logic [WORD_W-1:0] v_q, v_d;
   logic [TMO_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] result_q, result_d;
   logic              overflow_q, overflow_d;
   logic              err_q, err_d;
   logic              stop_q, stop_d;
   logic              accept;
   logic              uses_adder;
`ifdef FADD_CTRL_FCMP_EN
   cmp_e              cmp_q, cmp_d;
`endif

   // A command is taken only when fully idle, including the stop cycle
   assign accept = start && (state_q == ST_IDLE) && !stop_q;

`ifdef FADD_CTRL_FCMP_EN
   assign uses_adder = (op != OP_RSVD);
`else
   assign uses_adder = (op == OP_FADD) || (op == OP_FSUB);
`endif

   // Next-state, datapath capture and adder handshake
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      ra_d       = ra_q;
      v_d        = v_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      overflow_d = overflow_q;
      err_d      = err_q;
      stop_d     = 1'b0;
      fa_start   = 1'b0;
`ifdef FADD_CTRL_FCMP_EN
      cmp_d      = cmp_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d       = op_e'(op);
               ra_d       = ra;
               v_d        = v;
               cnt_d      = '0;
               err_d      = 1'b0;
               overflow_d = 1'b0;
               // reserved commands complete without touching the adder
               state_d    = uses_adder ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: begin
            fa_start = 1'b1;
            cnt_d    = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (fa_stop) begin
               state_d = ST_DONE;
`ifdef FADD_CTRL_FCMP_EN
               if (op_q == OP_FCMP) begin
                  if (fa_out[FRAC_MSB:FRAC_LSB] == '0) begin
                     cmp_d = CMP_EQ;
                  end else if (fa_out[SIGN_BIT]) begin
                     cmp_d = CMP_LT;
                  end else begin
                     cmp_d = CMP_GT;
                  end
               end else begin
                  result_d   = fa_out;
                  overflow_d = fa_overflow;
               end
`else
               result_d   = fa_out;
               overflow_d = fa_overflow;
`endif
            end else if (cnt_q == TMO_W'(TIMEOUT_LIMIT - 1)) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + TMO_W'(1);
            end
         end
         ST_DONE: begin
            stop_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and architectural registers; reset abandons any command
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_FADD;
         ra_q       <= '0;
         v_q        <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         overflow_q <= 1'b0;
         err_q      <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         ra_q       <= ra_d;
         v_q        <= v_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         overflow_q <= overflow_d;
         err_q      <= err_d;
         stop_q     <= stop_d;
      end
   end

`ifdef FADD_CTRL_FCMP_EN
   // Comparison indicator register
   always_ff @(posedge clk) begin
      if (reset) begin
         cmp_q <= CMP_EQ;
      end else begin
         cmp_q <= cmp_d;
      end
   end
   assign cmp = cmp_q;
`else
   assign cmp = CMP_EQ;
`endif

   // Operands stay on the adder inputs for the whole command since they
   // come straight from the latched copies
   assign fa_in1   = ra_q;
   assign fa_in2   = (op_q == OP_FADD) ? v_q : negate(v_q);

   // busy covers the whole command up to and including the stop pulse
   assign busy     = (state_q != ST_IDLE) || stop_q;
   assign stop     = stop_q;
   assign result   = result_q;
   assign overflow = overflow_q;
   assign err      = err_q;

endmodule

// File: tb/tb_fadd_ctrl.sv
// Bench for fadd_ctrl with a 3-cycle adder stand-in and a scoreboard of
// expected completions. Follows FADD_CTRL_FCMP_EN for FCMP expectations.
module tb_fadd_ctrl;
   import fpu_pkg::*;

`ifdef FADD_CTRL_FCMP_EN
   localparam bit FCMP_EN = 1'b1;
`else
   localparam bit FCMP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  op;
   logic [30:0] ra, v;
   logic        busy, stop, overflow, err, fa_start, fa_stop, fa_overflow;
   logic [30:0] result, fa_in1, fa_in2, fa_out;
   logic [1:0]  cmp;

   // adder stand-in: answers 3 cycles after fa_start (fa_start cycle counts)
   logic [30:0] adder_ret = '0;
   logic        adder_ovf = 1'b0;
   logic        adder_en  = 1'b1;
   logic        d1 = 1'b0, d2 = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      d1 <= fa_start;
      d2 <= d1 & adder_en;
   end
   assign fa_stop     = d2;
   assign fa_out      = adder_ret;
   assign fa_overflow = adder_ovf;

   fadd_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .ra(ra), .v(v),
      .busy(busy), .stop(stop), .result(result), .overflow(overflow),
      .cmp(cmp), .err(err), .fa_start(fa_start), .fa_in1(fa_in1),
      .fa_in2(fa_in2), .fa_out(fa_out), .fa_stop(fa_stop),
      .fa_overflow(fa_overflow)
   );

   typedef struct {
      logic [30:0] result;
      logic        ovf;
      logic [1:0]  cmp;
      logic        err;
      int          lat;
      int          op;
   } exp_t;

   exp_t        sb[$];
   exp_t        got;
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          t0 = 0;
   int          fa_start_cnt = 0;
   logic [30:0] exp_in1 = '0, exp_in2 = '0;
   // reference model of the architectural outputs
   logic [30:0] m_result = '0;
   logic        m_ovf = 1'b0, m_err = 1'b0;
   logic [1:0]  m_cmp = 2'b00;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", tag, act, req);
      end
   endtask

   // monitor: adder handshake and completions against the scoreboard
   always @(negedge clk) begin
      if (fa_start) begin
         fa_start_cnt++;
         chk("fa_in1", {1'b0, fa_in1}, {1'b0, exp_in1});
         chk("fa_in2", {1'b0, fa_in2}, {1'b0, exp_in2});
      end
      if (fa_stop && busy) chk("fa_in2_hold", {1'b0, fa_in2}, {1'b0, exp_in2});
      if (stop) begin
         if (sb.size() == 0) begin
            chk("stray_stop", {31'b0, stop}, 32'd0);
         end else begin
            got = sb.pop_front();
            chk("latency", cyc - t0, got.lat);
            chk("result", {1'b0, result}, {1'b0, got.result});
            chk("overflow", {31'b0, overflow}, {31'b0, got.ovf});
            chk("cmp", {30'b0, cmp}, {30'b0, got.cmp});
            chk("err", {31'b0, err}, {31'b0, got.err});
            $display("TXN op=%0d lat=%0d result=%h ovf=%0b cmp=%b err=%0b",
                     got.op, cyc - t0, result, overflow, cmp, err);
         end
      end
   end

   task automatic do_cmd(input logic [1:0] op_i, input logic [30:0] ra_i,
                         input logic [30:0] v_i, input logic [30:0] ret_i,
                         input logic ovf_i, input bit tmo, input bit dup);
      exp_t e;
      bit   uses;
      int   lat;
      uses      = (op_i == 2'd0) || (op_i == 2'd1) || ((op_i == 2'd2) && FCMP_EN);
      exp_in1   = ra_i;
      exp_in2   = (op_i == 2'd0) ? v_i : {~v_i[30], v_i[29:0]};
      adder_ret = ret_i;
      adder_ovf = ovf_i;
      adder_en  = !tmo;
      m_err     = 1'b0;
      m_ovf     = 1'b0;
      if (!uses) begin
         lat = 2;
      end else if (tmo) begin
         lat   = 11;
         m_err = 1'b1;
      end else begin
         lat = 5;
         if (op_i == 2'd2) begin
            m_cmp = (ret_i[23:0] == 24'd0) ? 2'b00 : (ret_i[30] ? 2'b01 : 2'b10);
         end else begin
            m_result = ret_i;
            m_ovf    = ovf_i;
         end
      end
      e.result = m_result; e.ovf = m_ovf; e.cmp = m_cmp; e.err = m_err;
      e.lat = lat; e.op = int'(op_i);
      sb.push_back(e);
      fa_start_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1; op = op_i; ra = ra_i; v = v_i; t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0; ra = 31'($urandom); v = 31'($urandom); op = 2'($urandom);
      chk("busy_rise", {31'b0, busy}, 32'd1);
      if (dup) begin
         @(posedge clk); #1;
         start = 1'b1; op = 2'd0;
         @(posedge clk); #1;
         start = 1'b0;
      end
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         chk("stop_wait", sb.size(), 32'd0);
         sb.delete();
      end
      repeat (3) @(posedge clk);
      #1;
      chk("fa_start_cnt", fa_start_cnt, {31'b0, uses});
      chk("busy_idle", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'd0; ra = '0; v = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_stop", {31'b0, stop}, 32'd0);
      chk("rst_fa_start", {31'b0, fa_start}, 32'd0);
      chk("rst_result", {1'b0, result}, 32'd0);
      chk("rst_overflow", {31'b0, overflow}, 32'd0);
      chk("rst_cmp", {30'b0, cmp}, 32'd0);
      chk("rst_err", {31'b0, err}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // arithmetic: 1.0+1.0, 1.0-1.0, overflowing add
      do_cmd(2'd0, 31'h21040000, 31'h21040000, 31'h21080000, 1'b0, 1'b0, 1'b0);
      do_cmd(2'd1, 31'h21040000, 31'h21040000, 31'h00000000, 1'b0, 1'b0, 1'b0);
      do_cmd(2'd0, 31'h3f7fffff, 31'h3f7fffff, 31'h007fffff, 1'b1, 1'b0, 1'b0);
      // comparisons: less, greater, equal (also clears the overflow above)
      do_cmd(2'd2, 31'h21040000, 31'h21080000, 31'h61040000, 1'b0, 1'b0, 1'b0);
      do_cmd(2'd2, 31'h21080000, 31'h21040000, 31'h21040000, 1'b0, 1'b0, 1'b0);
      do_cmd(2'd2, 31'h21040000, 31'h21040000, 31'h00000000, 1'b0, 1'b0, 1'b0);
      // reserved op
      do_cmd(2'd3, 31'h12345678, 31'h07654321, 31'h11111111, 1'b1, 1'b0, 1'b0);
      // adder timeout, then a good add clears err
      do_cmd(2'd0, 31'h21040000, 31'h21040000, 31'h22222222, 1'b0, 1'b1, 1'b0);
      do_cmd(2'd0, 31'h21040000, 31'h21040000, 31'h21080000, 1'b0, 1'b0, 1'b0);
      // start while busy is ignored
      do_cmd(2'd1, 31'h21080000, 31'h21040000, 31'h21040000, 1'b0, 1'b0, 1'b1);

      // reset during WAIT: no stop, late fa_stop ignored
      exp_in1 = 31'h21040000; exp_in2 = 31'h21040000;
      adder_ret = 31'h33333333; adder_ovf = 1'b1; adder_en = 1'b1;
      fa_start_cnt = 0;
      @(posedge clk); #1;
      start = 1'b1; op = 2'd0; ra = 31'h21040000; v = 31'h21040000;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_result = '0; m_ovf = 1'b0; m_cmp = 2'b00; m_err = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("rstmid_busy", {31'b0, busy}, 32'd0);
      chk("rstmid_result", {1'b0, result}, {1'b0, m_result});
      chk("rstmid_overflow", {31'b0, overflow}, {31'b0, m_ovf});
      chk("rstmid_fa_start", fa_start_cnt, 32'd1);

      // reset wins over start in the same cycle
      fa_start_cnt = 0;
      reset = 1'b1; start = 1'b1; op = 2'd0;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      chk("rststart_busy", {31'b0, busy}, 32'd0);
      repeat (8) @(posedge clk);
      #1;
      chk("rststart_fa_start", fa_start_cnt, 32'd0);

      // normal operation resumes after the reset cases
      do_cmd(2'd0, 31'h21040000, 31'h21040000, 31'h21080000, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
